// File: rtl/obi_slave_mem.sv
// OBI slave backed by a word-addressed memory: optional grant wait states and a
// fixed-latency, non-stalling response pipeline carrying {valid, err, data}.
module obi_slave_mem #(
  parameter int DEPTH    = 1024,
  parameter int LATENCY  = 1,
  parameter int GNT_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        gnt,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [1:0] WAIT_TGT = 2'(GNT_WAIT);

  logic [31:0]   r_mem [DEPTH];
  logic [1:0]    r_wait;
  logic          r_pv  [LATENCY];
  logic          r_pe  [LATENCY];
  logic [31:0]   r_pd  [LATENCY];

  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_gnt;
  logic [31:0]   w_rd_data;
  logic          w_unused;

  assign w_idx    = addr[AW+1:2];
  assign w_oor    = |addr[31:AW+2];
  assign w_unused = &{1'b0, addr[1:0]};

  // Grant once the wait counter has reached its target; never during reset.
  always_comb begin
    w_gnt = 1'b0;
    if (reset) begin
      w_gnt = 1'b0;
    end else begin
      w_gnt = req && (r_wait == WAIT_TGT);
    end
  end

  // Read data is captured at the acceptance edge; writes and errors respond with zero.
  always_comb begin
    w_rd_data = 32'd0;
    if (w_gnt && !we && !w_oor) begin
      w_rd_data = r_mem[w_idx];
    end else begin
      w_rd_data = 32'd0;
    end
  end

  // Wait counter: restarts whenever the request is withdrawn or accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= 2'd0;
    end else if (!req || w_gnt) begin
      r_wait <= 2'd0;
    end else begin
      r_wait <= r_wait + 2'd1;
    end
  end

  // Byte-masked memory write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_gnt && we && !w_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          r_mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Response shift pipeline; reset drops every in-flight response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pe[i] <= 1'b0;
        r_pd[i] <= 32'd0;
      end
    end else begin
      r_pv[0] <= w_gnt;
      r_pe[0] <= w_gnt && w_oor;
      r_pd[0] <= w_rd_data;
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign gnt    = w_gnt;
  assign rvalid = r_pv[LATENCY-1];
  assign err    = r_pe[LATENCY-1];
  assign rdata  = r_pd[LATENCY-1];

endmodule
